// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one synchronous-FIFO write port among NUM_REQ producers in bounded bursts.
// Optional macro FIFO_ARB_PRIO0_EN: producer 0 wins every arbitration and does not move the round-robin pointer.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4,
    localparam int GW        = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            ack,
    input  logic                          fifo_full,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_data,
    output logic [GW-1:0]                 grant_id,
    output logic                          busy
);

    // req/ack handshake: producer i holds req[i] and its word stable until ack[i]; ack[i] high
    // at a rising edge means that word is written into the FIFO on that edge. Dropping req
    // without ack withdraws the word and ends any grant that producer holds.

    localparam int            BW        = $clog2(MAX_BURST) + 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t        state, state_nxt;
    logic [GW-1:0] grant_q, grant_nxt;
    logic [GW-1:0] last_q, last_nxt;
    logic [BW-1:0] cnt_q, cnt_nxt;
    logic [GW-1:0] pick_id;
    logic          pick_valid;
    logic          owner_req;
    logic          wr_en;

    // Scan downward in distance so the nearest set request above last_q is written last and wins;
    // the GW-bit add wraps NUM_REQ-1 back to 0.
    always_comb begin
        logic [GW-1:0] idx;
        pick_valid = 1'b0;
        pick_id    = '0;
        idx        = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = last_q + GW'(k);
            if (req[idx]) begin
                pick_valid = 1'b1;
                pick_id    = idx;
            end
        end
`ifdef FIFO_ARB_PRIO0_EN
        if (req[0]) begin
            pick_valid = 1'b1;
            pick_id    = '0;
        end
`endif
    end

    assign owner_req = req[grant_q];
    assign wr_en     = (state == BURST) && owner_req && !fifo_full;

    always_comb begin
        state_nxt = state;
        grant_nxt = grant_q;
        last_nxt  = last_q;
        cnt_nxt   = cnt_q;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_nxt = BURST;
                    grant_nxt = pick_id;
                    cnt_nxt   = '0;
                end
            end
            BURST: begin
                if (wr_en) begin
                    cnt_nxt = cnt_q + 1'b1;
                end
                // fifo_full alone never ends a grant: the count is held and the owner keeps it.
                if ((wr_en && (cnt_q == LAST_BEAT)) || !owner_req) begin
                    state_nxt = IDLE;
`ifdef FIFO_ARB_PRIO0_EN
                    if (grant_q != '0) begin
                        last_nxt = grant_q;
                    end
`else
                    last_nxt = grant_q;
`endif
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            grant_q <= '0;
            last_q  <= GW'(NUM_REQ - 1);
            cnt_q   <= '0;
        end else begin
            state   <= state_nxt;
            grant_q <= grant_nxt;
            last_q  <= last_nxt;
            cnt_q   <= cnt_nxt;
        end
    end

    // Outputs decode from state, so an asynchronous reset drops the write strobe immediately.
    assign busy       = (state == BURST);
    assign fifo_wr_en = wr_en;
    assign grant_id   = grant_q;
    assign fifo_data  = busy ? req_data[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH] : '0;

    always_comb begin
        ack = '0;
        if (wr_en) begin
            ack[grant_q] = 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus random traffic against a transaction-level model.
// Honours FIFO_ARB_PRIO0_EN the same way as the design.
module tb_fifo_wr_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int DW        = 8;
    localparam int MAX_BURST = 4;
    localparam int GW        = $clog2(NUM_REQ);

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ*DW-1:0] req_data;
    logic                  fifo_full;
    logic [NUM_REQ-1:0]    ack;
    logic                  fifo_wr_en;
    logic [DW-1:0]         fifo_data;
    logic [GW-1:0]         grant_id;
    logic                  busy;

    fifo_wr_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .DATA_WIDTH(DW),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_data  (req_data),
        .ack       (ack),
        .fifo_full (fifo_full),
        .fifo_wr_en(fifo_wr_en),
        .fifo_data (fifo_data),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // producer state
    int                 want[NUM_REQ];
    int                 acks_seen[NUM_REQ];
    logic [DW-1:0]      pdata[NUM_REQ];
    logic [NUM_REQ-1:0] last_e_ack;
    logic               rand_mode;
    int                 bp_prod, bp_at, bp_left;

    // reference model: who owns the port, words taken this grant, round-robin pointer
    int m_owner, m_words, m_last;

    // scoreboard and observation logs
    logic [DW-1:0] exp_q[$];
    int            wr_cyc[$];
    logic [DW-1:0] wr_dat[$];
    int            gnt_q[$];
    int            gnt_cyc[$];
    logic          prev_busy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    function automatic int pick_winner(input logic [NUM_REQ-1:0] r, input int last);
        int w;
        w = -1;
`ifdef FIFO_ARB_PRIO0_EN
        if (r[0]) return 0;
`endif
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (w < 0 && r[(last + k) % NUM_REQ]) w = (last + k) % NUM_REQ;
        end
        return w;
    endfunction

    // driver tasks
    task automatic drive_inputs();
        for (int i = 0; i < NUM_REQ; i++) begin
            req[i]                = (want[i] > 0);
            req_data[i*DW +: DW]  = pdata[i];
        end
    endtask

    task automatic start_prod(input int i, input int n, input logic [DW-1:0] base);
        want[i]  = n;
        pdata[i] = base;
        drive_inputs();
    endtask

    task automatic update_producers();
        for (int i = 0; i < NUM_REQ; i++) begin
            if (last_e_ack[i]) begin
                want[i]--;
                acks_seen[i]++;
                pdata[i] = rand_mode ? DW'($urandom) : pdata[i] + 8'h11;
            end
            if (rand_mode) begin
                if (want[i] == 0) begin
                    if ($urandom_range(0, 5) == 0) begin
                        want[i]  = int'($urandom_range(1, 9));
                        pdata[i] = DW'($urandom);
                    end
                end else if (!last_e_ack[i] && $urandom_range(0, 39) == 0) begin
                    want[i] = 0;
                end
            end
        end
        last_e_ack = '0;
        if (rand_mode) begin
            fifo_full = ($urandom_range(0, 3) == 0);
        end else if (bp_left > 0 && acks_seen[bp_prod] == bp_at) begin
            fifo_full = 1'b1;
            bp_left--;
        end else begin
            fifo_full = 1'b0;
        end
        drive_inputs();
    endtask

    task automatic model_reset();
        m_owner   = -1;
        m_words   = 0;
        m_last    = NUM_REQ - 1;
        prev_busy = 1'b0;
        last_e_ack = '0;
        exp_q.delete();
        wr_cyc.delete();
        wr_dat.delete();
        gnt_q.delete();
        gnt_cyc.delete();
    endtask

    task automatic model_and_check();
        logic [NUM_REQ-1:0] e_ack;
        logic               e_wr;
        logic               e_busy;
        logic [DW-1:0]      e_data;
        e_ack  = '0;
        e_wr   = 1'b0;
        e_busy = 1'b0;
        e_data = '0;
        if (m_owner >= 0) begin
            e_busy = 1'b1;
            e_data = pdata[m_owner];
            e_wr   = req[m_owner] && !fifo_full;
            if (e_wr) e_ack[m_owner] = 1'b1;
        end

        chk("busy", 32'(busy), 32'(e_busy));
        chk("wr_en", 32'(fifo_wr_en), 32'(e_wr));
        chk("ack", 32'(ack), 32'(e_ack));
        chk("data", 32'(fifo_data), 32'(e_data));
        if (e_busy) chk("grant", 32'(grant_id), 32'(m_owner));

        if (e_wr) exp_q.push_back(e_data);
        if (fifo_wr_en) begin
            wr_cyc.push_back(cyc);
            wr_dat.push_back(fifo_data);
            if (exp_q.size() == 0) chk("sb_extra_write", 32'(1), 32'(0));
            else chk("sb_data", 32'(fifo_data), 32'(exp_q.pop_front()));
        end
        if (busy && !prev_busy) begin
            gnt_q.push_back(int'(grant_id));
            gnt_cyc.push_back(cyc);
        end
        prev_busy  = busy;
        last_e_ack = e_ack;

        // advance the model to the state after the coming edge
        if (m_owner < 0) begin
            if (req != '0) begin
                m_owner = pick_winner(req, m_last);
                m_words = 0;
            end
        end else begin
            if (e_wr) m_words++;
            if ((e_wr && m_words == MAX_BURST) || !req[m_owner]) begin
`ifdef FIFO_ARB_PRIO0_EN
                if (m_owner != 0) m_last = m_owner;
`else
                m_last = m_owner;
`endif
                m_owner = -1;
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        cyc++;
        model_and_check();
        @(posedge clk);
        #1;
        update_producers();
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        rand_mode = 1'b0;
        bp_left   = 0;
        fifo_full = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            want[i]      = 0;
            acks_seen[i] = 0;
            pdata[i]     = '0;
        end
        drive_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_wr_en", 32'(fifo_wr_en), 32'(0));
        chk("rst_ack", 32'(ack), 32'(0));
        chk("rst_data", 32'(fifo_data), 32'(0));
        chk("rst_grant", 32'(grant_id), 32'(0));
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int exp_rr[5];
        req       = '0;
        req_data  = '0;
        fifo_full = 1'b0;

        // reset then idle
        do_reset();
        repeat (10) cycle();

        // single producer, two bursts with one idle cycle between
        t0 = cyc;
        start_prod(2, 8, 8'h11);
        repeat (14) cycle();
        chk("sp_nwrites", 32'(wr_dat.size()), 32'(8));
        if (wr_dat.size() >= 8) begin
            for (int k = 0; k < 8; k++) chk("sp_word", 32'(wr_dat[k]), 32'((k + 1) * 17));
            chk("sp_first_lat", 32'(wr_cyc[0]), 32'(t0 + 2));
            chk("sp_burst_end", 32'(wr_cyc[3]), 32'(t0 + 5));
            chk("sp_bubble", 32'(wr_cyc[4]), 32'(t0 + 7));
            chk("sp_last", 32'(wr_cyc[7]), 32'(t0 + 10));
        end

        // round robin with every producer requesting
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) start_prod(i, 8, DW'(16 * i + 1));
`ifdef FIFO_ARB_PRIO0_EN
        exp_rr = '{0, 0, 1, 2, 3};
`else
        exp_rr = '{0, 1, 2, 3, 0};
`endif
        repeat (27) cycle();
        chk("rr_ngrants", 32'(gnt_q.size() >= 5), 32'(1));
        if (gnt_q.size() >= 5) begin
            for (int k = 0; k < 5; k++) chk("rr_order", 32'(gnt_q[k]), 32'(exp_rr[k]));
            for (int k = 0; k < 4; k++) chk("rr_spacing", 32'(gnt_cyc[k+1] - gnt_cyc[k]), 32'(MAX_BURST + 1));
        end

        // back-pressure for 3 cycles after word 2
        do_reset();
        bp_prod = 1;
        bp_at   = 2;
        bp_left = 3;
        start_prod(1, 4, 8'h21);
        repeat (12) cycle();
        chk("bp_nwrites", 32'(wr_dat.size()), 32'(4));
        chk("bp_ngrants", 32'(gnt_q.size()), 32'(1));
        if (wr_dat.size() >= 4) begin
            chk("bp_stall_gap", 32'(wr_cyc[2] - wr_cyc[1]), 32'(4));
            chk("bp_word2", 32'(wr_dat[2]), 32'(8'h43));
            chk("bp_word3", 32'(wr_dat[3]), 32'(8'h54));
        end

        // early drop by producer 1 leaves the pointer at 1
        do_reset();
        start_prod(1, 2, 8'hA1);
        repeat (6) cycle();
        start_prod(0, 1, 8'h05);
        start_prod(2, 1, 8'h06);
        repeat (6) cycle();
        chk("ed_ngrants", 32'(gnt_q.size()), 32'(3));
        if (gnt_q.size() >= 2) begin
            chk("ed_first", 32'(gnt_q[0]), 32'(1));
`ifdef FIFO_ARB_PRIO0_EN
            chk("ed_next", 32'(gnt_q[1]), 32'(0));
`else
            chk("ed_next", 32'(gnt_q[1]), 32'(2));
`endif
        end
        if (wr_dat.size() >= 2) begin
            chk("ed_w0", 32'(wr_dat[0]), 32'(8'hA1));
            chk("ed_w1", 32'(wr_dat[1]), 32'(8'hB2));
        end

        // req[0] and req[3] together after a producer-0 grant
        do_reset();
        start_prod(0, 1, 8'h01);
        repeat (6) cycle();
        start_prod(0, 1, 8'h02);
        start_prod(3, 1, 8'h03);
        repeat (4) cycle();
        if (gnt_q.size() >= 2) begin
`ifdef FIFO_ARB_PRIO0_EN
            chk("prio_grant", 32'(gnt_q[1]), 32'(0));
`else
            chk("prio_grant", 32'(gnt_q[1]), 32'(3));
`endif
        end else begin
            chk("prio_ngrants", 32'(gnt_q.size()), 32'(2));
        end

        // asynchronous reset in the middle of a burst
        do_reset();
        start_prod(2, 50, 8'h40);
        repeat (3) cycle();
        chk("pre_rst_wr", 32'(fifo_wr_en), 32'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_wr", 32'(fifo_wr_en), 32'(0));
        chk("mid_rst_ack", 32'(ack), 32'(0));
        chk("mid_rst_busy", 32'(busy), 32'(0));
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        start_prod(0, 2, 8'h70);
        start_prod(1, 2, 8'h80);
        repeat (4) cycle();
        if (gnt_q.size() >= 1) chk("post_rst_grant", 32'(gnt_q[0]), 32'(0));
        else chk("post_rst_ngrants", 32'(gnt_q.size()), 32'(1));

        // random traffic against the model
        do_reset();
        rand_mode = 1'b1;
        repeat (2000) cycle();
        rand_mode = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) want[i] = 0;
        drive_inputs();
        repeat (12) cycle();
        chk("sb_drain", 32'(exp_q.size()), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
